// File: rtl/hazard_if.sv
// Hazard-detection bundle between the ID/EX pipeline registers and the hazard unit.
// The pipeline drives the decode fields through master; the hazard unit answers with stall controls through slave.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             IFID_UsesRt;
  logic             IFID_HiLoRead;
  logic             IFID_HiLoStart;
  logic             HazardMuxSelect;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             MulBusy;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
           IFID_HiLoRead, IFID_HiLoStart,
    input  HazardMuxSelect, PCWrite, IFIDWrite, MulBusy, StallCycles
  );

  modport slave (
    input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
           IFID_HiLoRead, IFID_HiLoStart,
    output HazardMuxSelect, PCWrite, IFIDWrite, MulBusy, StallCycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use detection, HI/LO busy tracking for mult/div,
// and a saturating count of stalled cycles.
module hazard_unit #(
  parameter int unsigned MUL_LAT = 4,   // legal range 1..15 (4-bit down-counter)
  parameter int unsigned CNT_W   = 16
) (
  input logic   clk,
  input logic   reset,
  hazard_if.slave hz
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             hilo_stall;
  logic             stall;
  logic             hilo_op;

  // Hazard detection. Register 0 is hard-wired, so a load into it never creates a dependency.
  always_comb begin
    load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
               ((hz.IDEX_Rt == hz.IFID_Rs) ||
                (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));
    hilo_op    = hz.IFID_HiLoRead || hz.IFID_HiLoStart;
    hilo_stall = (state == BUSY) && hilo_op;
    stall      = load_use || hilo_stall;
  end

  // Reset forces a bubble so nothing half-decoded leaks into EX while the core comes up.
  assign hz.HazardMuxSelect = stall || reset;
  assign hz.PCWrite         = !(stall || reset);
  assign hz.IFIDWrite       = !(stall || reset);
  assign hz.MulBusy         = (state == BUSY);
  assign hz.StallCycles     = stall_cnt;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        // A mult/div held back by a load-use bubble is not issued; it retries next cycle.
        if (hz.IFID_HiLoStart && !load_use) begin
          state_nxt = BUSY;
          cnt_nxt   = LAT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturates at all-ones; coincident load-use and HI/LO stalls are one stalled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles HI/LO stays busy after a mult/div issues; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IDEX_MemRead  input  1  instruction in EX is a load.
REQ-006 IDEX_Rt  input  5  destination register of the EX-stage load.
REQ-007 IFID_Rs  input  5  source register rs of the ID-stage instruction.
REQ-008 IFID_Rt  input  5  source register rt of the ID-stage instruction.
REQ-009 IFID_UsesRt  input  1  ID-stage instruction reads rt as a source.
REQ-010 IFID_HiLoRead  input  1  ID-stage instruction is mfhi/mflo.
REQ-011 IFID_HiLoStart  input  1  ID-stage instruction is mult/multu/div/divu.
REQ-012 HazardMuxSelect  output  1  1 = stall mux zeroes the wb/m/ex control bundles (bubble).
REQ-013 PCWrite  output  1  1 = PC may update.
REQ-014 IFIDWrite  output  1  1 = IF/ID register may load.
REQ-015 MulBusy  output  1  HI/LO unit busy.
REQ-016 StallCycles  output  CNT_W  saturating count of stalled cycles since reset.

Function
REQ-017 load_use = IDEX_MemRead & (IDEX_Rt != 0) & ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt))); purely combinational.
REQ-018 hilo_stall = MulBusy & (IFID_HiLoRead | IFID_HiLoStart); purely combinational.
REQ-019 stall = load_use | hilo_stall; HazardMuxSelect = stall, PCWrite = ~stall, IFIDWrite = ~stall, all combinational, same cycle.
REQ-020 FSM has two states: IDLE and BUSY; MulBusy = 1 exactly when state is BUSY.
REQ-021 IDLE -> BUSY on an edge where IFID_HiLoStart = 1 and load_use = 0; the 4-bit down-counter loads MUL_LAT-1 on that edge.
REQ-022 IDLE with IFID_HiLoStart = 1 and load_use = 1: stay IDLE, counter unchanged (mult not issued; retried next cycle).
REQ-023 BUSY with counter != 0: decrement by 1 per cycle, stay BUSY.
REQ-024 BUSY with counter == 0: -> IDLE on the next edge; MulBusy is 1 for exactly MUL_LAT cycles after the issue edge.
REQ-025 A HiLoStart or HiLoRead arriving during the last BUSY cycle (counter == 0) is still stalled; it proceeds the following cycle, when IDLE, and a HiLoStart then re-enters BUSY with a fresh count.
REQ-026 StallCycles increments by 1 on every edge where stall = 1; it holds at all-ones (2^CNT_W - 1) and never wraps.
REQ-027 IDEX_Rt = 0 never causes a load-use stall, even if rs/rt = 0.
REQ-028 Simultaneous load_use and hilo_stall count once in StallCycles.

Reset
REQ-029 While reset = 1: state = IDLE, counter = 0, MulBusy = 0, StallCycles = 0, immediately and independent of clk.
REQ-030 While reset = 1: HazardMuxSelect = 1, PCWrite = 0, IFIDWrite = 0, and StallCycles does not count.
REQ-031 Reset asserted in BUSY aborts the operation; after release the FSM is IDLE with MulBusy = 0.

Verification
REQ-032 IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> HazardMuxSelect=1, PCWrite=0, IFIDWrite=0 same cycle; StallCycles 0->1 at next edge.
REQ-033 IDEX_MemRead=1, IDEX_Rt=0, IFID_Rs=0 -> no stall; IDEX_Rt=9, IFID_Rt=9, IFID_UsesRt=0 -> no stall; same values with IFID_UsesRt=1 -> stall.
REQ-034 MUL_LAT=4: HiLoStart pulse one cycle, then IFID_HiLoRead=1 held -> MulBusy=1 for 4 cycles, HazardMuxSelect=1 for those 4 cycles, then 0; StallCycles=4.
REQ-035 IDLE, IFID_HiLoStart=1 together with load_use=1 for 1 cycle -> stays IDLE, stall=1; next cycle load_use=0 -> BUSY entered.
REQ-036 Assert reset 2 cycles into BUSY -> MulBusy=0 and StallCycles=0 at once; outputs 1/0/0 during reset; after release, no stall with idle inputs.
REQ-037 CNT_W=4, hold load_use=1 for 20 cycles -> StallCycles reaches 15 and stays 15.
